// File: rtl/morse_pkg.sv
// Shared Morse timing constants and receiver FSM encoding.
// The encoder imports the same package so both sides agree on unit multiples.
package morse_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MARK  = 2'd1;
  localparam logic [1:0] ST_SPACE = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Thresholds expressed as multiples of one dot unit
  localparam int unsigned DASH_MIN = 2;
  localparam int unsigned CHAR_GAP = 2;
  localparam int unsigned WORD_GAP = 5;
  localparam int unsigned STUCK    = 8;

endpackage

// File: rtl/morse_sync.sv
// Two-flop synchronizer for the asynchronous key line, with edge detection.
// Edges are suppressed until the pipeline holds real samples, so a line already high at reset release is not a rise.
module morse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh_q;
  logic [2:0] fill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      fill_q <= '0;
    end else begin
      sh_q   <= {sh_q[1:0], din};
      fill_q <= {fill_q[1:0], 1'b1};
    end
  end

  assign level = sh_q[1];
  assign rise  = fill_q[2] &  sh_q[1] & ~sh_q[2];
  assign fall  = fill_q[2] & ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/morse_rx.sv
// Morse receiver: times mark/space runs of the synchronized key line and emits
// one character (dash=1, dot=0, first element in bit 0) per inter-character gap.
module morse_rx
  import morse_pkg::*;
#(
  parameter int unsigned UNIT   = 4,
  parameter int unsigned MAXSYM = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in,
  output logic [MAXSYM-1:0] sym_bits,
  output logic [2:0]        sym_len,
  output logic              sym_valid,
  output logic              word_gap,
  output logic              err
);

  localparam int unsigned CW = $clog2(STUCK * UNIT + 1);
  localparam logic [CW-1:0] T_DASH  = CW'(DASH_MIN * UNIT);
  localparam logic [CW-1:0] T_CHAR  = CW'(CHAR_GAP * UNIT);
  localparam logic [CW-1:0] T_WORD  = CW'(WORD_GAP * UNIT);
  localparam logic [CW-1:0] T_STUCK = CW'(STUCK * UNIT);
  localparam logic [2:0]    LEN_MAX = 3'(MAXSYM);

  logic key_lvl, key_rise, key_fall;

  morse_sync u_sync (
    .clk   (clk),
    .rst_n (rst),
    .din   (key_in),
    .level (key_lvl),
    .rise  (key_rise),
    .fall  (key_fall)
  );

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [MAXSYM-1:0] buf_q, buf_d;
  logic [2:0]        len_q, len_d;
  logic [MAXSYM-1:0] bits_q, bits_d;
  logic [2:0]        slen_q, slen_d;
  logic              valid_q, valid_d;
  logic              wgap_q, wgap_d;
  logic              err_q, err_d;

  // A threshold T is "reached" on the cycle the counter steps to T, so the
  // run length compared is the incremented count.
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    len_d   = len_q;
    bits_d  = '0;
    slen_d  = '0;
    valid_d = 1'b0;
    wgap_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_rise) begin
          state_d = ST_MARK;
          cnt_d   = '0;
        end
      end

      ST_MARK: begin
        if (key_fall) begin
          if (len_q == LEN_MAX) begin
            err_d = 1'b1;
            buf_d = '0;
            len_d = '0;
          end else begin
            for (int unsigned i = 0; i < MAXSYM; i++) begin
              if (i == 32'(len_q)) buf_d[i] = (cnt_inc >= T_DASH);
            end
            len_d = len_q + 3'd1;
          end
          cnt_d   = '0;
          state_d = ST_SPACE;
        end else if (cnt_inc == T_STUCK) begin
          err_d   = 1'b1;
          buf_d   = '0;
          len_d   = '0;
          cnt_d   = '0;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_SPACE: begin
        if (cnt_q < T_WORD) cnt_d = cnt_inc;
        if (cnt_inc == T_CHAR && len_q != '0) begin
          valid_d = 1'b1;
          bits_d  = buf_q;
          slen_d  = len_q;
          buf_d   = '0;
          len_d   = '0;
        end
        if (cnt_inc == T_WORD) begin
          wgap_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
        // Threshold actions above still fire when a rise coincides with them
        if (key_rise) begin
          cnt_d   = '0;
          state_d = ST_MARK;
        end
      end

      ST_HOLD: begin
        // Only reachable with the line high, so a low level marks its falling edge
        cnt_d = '0;
        if (!key_lvl) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      len_q   <= '0;
      bits_q  <= '0;
      slen_q  <= '0;
      valid_q <= 1'b0;
      wgap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      bits_q  <= bits_d;
      slen_q  <= slen_d;
      valid_q <= valid_d;
      wgap_q  <= wgap_d;
      err_q   <= err_d;
    end
  end

  assign sym_bits  = bits_q;
  assign sym_len   = slen_q;
  assign sym_valid = valid_q;
  assign word_gap  = wgap_q;
  assign err       = err_q;

endmodule

// File: tb/tb_morse_rx.sv
// Directed bench for morse_rx (UNIT=4, MAXSYM=6): run-length vectors plus
// latency, stuck-mark and reset sequences.
module tb_morse_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_in;
  logic [5:0] sym_bits;
  logic [2:0] sym_len;
  logic       sym_valid, word_gap, err;

  always #5 clk = ~clk;

  morse_rx #(.UNIT(4), .MAXSYM(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .sym_bits  (sym_bits),
    .sym_len   (sym_len),
    .sym_valid (sym_valid),
    .word_gap  (word_gap),
    .err       (err)
  );

  int unsigned checks, errors;

  // Pulse monitor, sampled on the falling edge
  int unsigned nvalid, nwg, nerr;
  logic [5:0]  vbits [4];
  logic [2:0]  vlen  [4];
  int unsigned vwg   [4];

  always @(negedge clk) begin
    if (sym_valid) begin
      if (nvalid < 4) begin
        vbits[nvalid] = sym_bits;
        vlen[nvalid]  = sym_len;
        vwg[nvalid]   = nwg;
      end
      nvalid++;
    end
    if (word_gap) nwg++;
    if (err) nerr++;
  end

  typedef struct packed {
    logic [3:0]      n;
    logic [7:0][7:0] hi;
    logic [7:0][7:0] lo;
    logic [2:0]      nvalid;
    logic [5:0]      bits0;
    logic [2:0]      len0;
    logic [5:0]      bits1;
    logic [2:0]      len1;
    logic [1:0]      nwg;
    logic [1:0]      nerr;
  } vec_t;

  localparam int NV = 9;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    nvalid = 0;
    nwg    = 0;
    nerr   = 0;
    for (int i = 0; i < 4; i++) begin
      vbits[i] = '0;
      vlen[i]  = '0;
      vwg[i]   = 0;
    end
  endtask

  task automatic drive(input logic lv, input int unsigned n);
    key_in = lv;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_run(input int i, input int unsigned h, input int unsigned l);
    vt[i].hi[vt[i].n] = 8'(h);
    vt[i].lo[vt[i].n] = 8'(l);
    vt[i].n = vt[i].n + 4'd1;
  endtask

  task automatic set_exp(input int i, input int unsigned nv, input logic [5:0] b0, input logic [2:0] l0,
                         input logic [5:0] b1, input logic [2:0] l1, input int unsigned wg, input int unsigned er);
    vt[i].nvalid = 3'(nv);
    vt[i].bits0  = b0;
    vt[i].len0   = l0;
    vt[i].bits1  = b1;
    vt[i].len1   = l1;
    vt[i].nwg    = 2'(wg);
    vt[i].nerr   = 2'(er);
  endtask

  task automatic out_zero(input string pfx);
    chk({pfx, "_sym_valid"}, 32'(sym_valid), 0);
    chk({pfx, "_word_gap"},  32'(word_gap),  0);
    chk({pfx, "_err"},       32'(err),       0);
    chk({pfx, "_sym_bits"},  32'(sym_bits),  0);
    chk({pfx, "_sym_len"},   32'(sym_len),   0);
  endtask

  int unsigned k;
  logic        got;

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    key_in = 1'b0;
    clear_mon();

    repeat (2) @(posedge clk);
    #1;
    out_zero("reset");
    rst = 1'b1;
    drive(0, 5);

    for (int i = 0; i < NV; i++) vt[i] = '0;
    // "A": dot, dash
    add_run(0, 4, 4);  add_run(0, 12, 20);
    set_exp(0, 1, 6'b000010, 3'd2, 6'b0, 3'd0, 1, 0);
    // "E" then "T" with a 12-cycle gap
    add_run(1, 4, 12); add_run(1, 12, 20);
    set_exp(1, 2, 6'b000000, 3'd1, 6'b000001, 3'd1, 1, 0);
    // seven dots overflow the buffer
    for (int j = 0; j < 6; j++) add_run(2, 4, 4);
    add_run(2, 4, 20);
    set_exp(2, 0, 6'b0, 3'd0, 6'b0, 3'd0, 1, 1);
    // mark of 7 is a dot, 8 is a dash
    add_run(3, 7, 20);
    set_exp(3, 1, 6'b000000, 3'd1, 6'b0, 3'd0, 1, 0);
    add_run(4, 8, 20);
    set_exp(4, 1, 6'b000001, 3'd1, 6'b0, 3'd0, 1, 0);
    // gap of 7 keeps the character, gap of 8 emits it
    add_run(5, 4, 7);  add_run(5, 8, 20);
    set_exp(5, 1, 6'b000010, 3'd2, 6'b0, 3'd0, 1, 0);
    add_run(6, 4, 8);  add_run(6, 8, 20);
    set_exp(6, 2, 6'b000000, 3'd1, 6'b000001, 3'd1, 1, 0);
    // full six-element character: dash dot dash dot dash dash
    add_run(7, 12, 4); add_run(7, 4, 4); add_run(7, 12, 4);
    add_run(7, 4, 4);  add_run(7, 12, 4); add_run(7, 12, 20);
    set_exp(7, 1, 6'b110101, 3'd6, 6'b0, 3'd0, 1, 0);
    // stuck mark
    add_run(8, 40, 20);
    set_exp(8, 0, 6'b0, 3'd0, 6'b0, 3'd0, 0, 1);

    for (int i = 0; i < NV; i++) begin
      clear_mon();
      for (int j = 0; j < int'(vt[i].n); j++) begin
        drive(1, int'(vt[i].hi[j]));
        drive(0, int'(vt[i].lo[j]));
      end
      drive(0, 30);
      chk($sformatf("v%0d_nvalid", i), nvalid, 32'(vt[i].nvalid));
      chk($sformatf("v%0d_nwg", i),    nwg,    32'(vt[i].nwg));
      chk($sformatf("v%0d_nerr", i),   nerr,   32'(vt[i].nerr));
      if (vt[i].nvalid >= 3'd1) begin
        chk($sformatf("v%0d_bits0", i), 32'(vbits[0]), 32'(vt[i].bits0));
        chk($sformatf("v%0d_len0", i),  32'(vlen[0]),  32'(vt[i].len0));
      end
      if (vt[i].nvalid >= 3'd2) begin
        chk($sformatf("v%0d_bits1", i),   32'(vbits[1]), 32'(vt[i].bits1));
        chk($sformatf("v%0d_len1", i),    32'(vlen[1]),  32'(vt[i].len1));
        chk($sformatf("v%0d_wg_mid", i),  vwg[1],        0);
      end
    end

    // sym_valid latency 2*UNIT+3, word_gap latency 5*UNIT+3 from the key fall
    clear_mon();
    drive(1, 4);
    key_in = 1'b0;
    k = 0;
    got = 1'b0;
    while (!got && k < 60) begin
      @(posedge clk); #1; k++;
      if (sym_valid) got = 1'b1;
    end
    chk("valid_latency", k, 11);
    got = 1'b0;
    while (!got && k < 60) begin
      @(posedge clk); #1; k++;
      if (word_gap) got = 1'b1;
    end
    chk("wgap_latency", k, 23);
    drive(0, 10);

    // stuck mark: err 8*UNIT+3 cycles after the key rise, then silence, then recovery
    clear_mon();
    key_in = 1'b1;
    k = 0;
    got = 1'b0;
    while (!got && k < 60) begin
      @(posedge clk); #1; k++;
      if (err) got = 1'b1;
    end
    chk("stuck_err_latency", k, 35);
    if (k < 40) drive(1, 40 - k);
    drive(0, 30);
    chk("stuck_nvalid", nvalid, 0);
    chk("stuck_nwg", nwg, 0);
    chk("stuck_nerr", nerr, 1);
    clear_mon();
    drive(1, 4);
    drive(0, 30);
    chk("recover_nvalid", nvalid, 1);
    chk("recover_len", 32'(vlen[0]), 1);

    // asynchronous reset clears a pulse already on the outputs
    clear_mon();
    drive(1, 12);
    key_in = 1'b0;
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); #1; k++;
      if (sym_valid) got = 1'b1;
    end
    chk("arst_pulse_seen", 32'(got), 1);
    #2 rst = 1'b0;
    #1;
    out_zero("arst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    drive(0, 5);

    // reset two cycles into the dash of "A", key still high at release
    clear_mon();
    drive(1, 4);
    drive(0, 4);
    key_in = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    out_zero("midrst");
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    drive(1, 10);
    drive(0, 30);
    chk("midrst_nvalid", nvalid, 0);
    chk("midrst_nwg", nwg, 0);
    chk("midrst_nerr", nerr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_rx.md
MORSE_RX -- requirements
Module: morse_rx

Interface
REQ-001 Parameter UNIT, default 4, gives clock cycles per Morse dot unit; legal range 2..64.
REQ-002 Parameter MAXSYM, default 6, gives the maximum number of elements per character.
REQ-003 Port clk  input  1  is the single clock; it is the divided unit clock domain of the encoder.
REQ-004 Port rst  input  1  is the reset: asynchronous, active-low.
REQ-005 Port key_in  input  1  is the keyed Morse line (encoder LED output); it is asynchronous to clk.
REQ-006 Port sym_bits  output  MAXSYM  holds the received character elements: first element in bit 0, dash=1, dot=0; unused upper bits are 0.
REQ-007 Port sym_len  output  3  gives the element count of sym_bits, 1..MAXSYM.
REQ-008 Port sym_valid  output  1  is a one-cycle pulse; sym_bits and sym_len are valid only on that cycle.
REQ-009 Port word_gap  output  1  is a one-cycle pulse on word-space detection.
REQ-010 Port err  output  1  is a one-cycle pulse on overflow or stuck-mark.

Function
REQ-011 key_in shall pass through a 2-flop synchronizer; edges shall be detected on the synchronized value; all timing below counts from the detected edge.
REQ-012 FSM states shall be IDLE, MARK, SPACE and HOLD.
REQ-013 IDLE: on a rising edge, go to MARK and clear the run counter.
REQ-014 MARK: increment the counter each cycle, saturating at 8*UNIT.
REQ-015 MARK, falling edge: a run shorter than 2*UNIT cycles is a dot; 2*UNIT or more is a dash; append the element at index sym_len_int, increment sym_len_int, clear the counter, go to SPACE.
REQ-016 MARK, falling edge with sym_len_int already equal to MAXSYM: pulse err, discard the buffer, go to SPACE; the character is not emitted.
REQ-017 MARK, counter reaching 8*UNIT (stuck mark): pulse err, discard the buffer, go to HOLD.
REQ-018 HOLD: wait for a falling edge, then go to IDLE with no output.
REQ-019 SPACE: increment the counter, saturating at 5*UNIT.
REQ-020 SPACE, rising edge before the counter reaches 2*UNIT: this is an intra-character gap; go to MARK and keep the buffer.
REQ-021 SPACE, counter reaching 2*UNIT with sym_len_int>0: pulse sym_valid for exactly one cycle with the buffer contents, then clear the buffer.
REQ-022 SPACE, rising edge after the character has been emitted but before 5*UNIT: go to MARK and start a new character; no word_gap is produced.
REQ-023 SPACE, counter reaching 5*UNIT: pulse word_gap once, go to IDLE.
REQ-024 A rising edge in the same cycle the counter reaches a threshold: the threshold action takes priority, then go to MARK.
REQ-025 Output latency: sym_valid asserts exactly 2*UNIT+3 cycles after the falling edge of the last key_in mark.
REQ-026 The counter width shall be clog2(8*UNIT+1); it shall never wrap.

Reset
REQ-027 On rst low, the module shall asynchronously enter IDLE and clear the synchronizer, counter, buffer and sym_len_int.
REQ-028 Reset values: sym_bits=0, sym_len=0, sym_valid=0, word_gap=0, err=0.
REQ-029 Reset mid-character shall discard the partial character with no pulse on any output.
REQ-030 After reset release, the first qualifying rising edge on key_in starts a mark; a key_in already high at release shall not count until a low is seen.

Structure
REQ-031 Package morse_pkg shall hold the FSM state encoding and the threshold multipliers (DASH_MIN=2, CHAR_GAP=2, WORD_GAP=5, STUCK=8); the encoder shall share it.
REQ-032 One sub-module, morse_sync, shall be the 2-flop synchronizer with edge detect (outputs: level, rise, fall).

Verification (UNIT=4, MAXSYM=6)
REQ-033 "A": high 4, low 4, high 12, low 20 -> sym_valid with sym_bits=000010 and sym_len=2, then one word_gap pulse.
REQ-034 "E" then "T" separated by 12 low cycles -> two sym_valid pulses (000000/len 1, then 000001/len 1) and no word_gap between them.
REQ-035 Seven dots with 4-cycle gaps -> err pulse on the 7th falling edge, no sym_valid, then word_gap after 20 low cycles.
REQ-036 key_in held high 40 cycles -> err pulse 32 cycles after the sync'd rise, no sym_valid after release, FSM returns to IDLE.
REQ-037 Boundary runs: high 7 -> dot, high 8 -> dash; low 7 then rise -> same character, low 8 -> emit.
REQ-038 rst asserted 2 cycles into the second element of "A" -> all outputs 0 immediately, no pulse afterward.
